// File: rtl/dispatch_scheduler_if.sv
// Fetch-side and issue-side signal bundle for dispatch_scheduler.
// master drives fetch/backpressure/flush; slave is the scheduler.
interface dispatch_scheduler_if;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        iq_full;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        rollback;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        issue_to_lsb;
  logic [31:0] perf_issued;
  logic [31:0] perf_stalls;

  modport master (
    output fetch_valid, fetch_inst, fetch_pc,
    output rob_full, rs_full, lsb_full, rollback,
    input  iq_full, issue_valid, issue_inst,
    input  issue_pc, issue_to_lsb,
    input  perf_issued, perf_stalls
  );

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc,
    input  rob_full, rs_full, lsb_full, rollback,
    output iq_full, issue_valid, issue_inst,
    output issue_pc, issue_to_lsb,
    output perf_issued, perf_stalls
  );
endinterface

// File: rtl/dispatch_scheduler.sv
// Instruction queue issuing one instruction/cycle to RS or LSB.
// Optional perf counters enabled by macro ISSUE_PERF_CNT_EN.
module dispatch_scheduler #(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_PTR_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  dispatch_scheduler_if.slave bus
);

  localparam logic [IQ_PTR_W-1:0] PTR_ONE = 1;
  localparam logic [IQ_PTR_W:0]   CNT_ONE = 1;
  localparam logic [IQ_PTR_W:0]   CNT_FULL =
    (IQ_PTR_W+1)'(IQ_DEPTH);

  logic [31:0] inst_q [IQ_DEPTH];
  logic [31:0] pc_q   [IQ_DEPTH];

  logic [IQ_PTR_W-1:0] head_q, head_d;
  logic [IQ_PTR_W-1:0] tail_q, tail_d;
  logic [IQ_PTR_W:0]   count_q, count_d;
  logic        iv_q, iv_d;
  logic [31:0] ii_q, ii_d;
  logic [31:0] ipc_q, ipc_d;
  logic        lsb_q, lsb_d;

  logic [31:0] head_inst;
  logic [31:0] head_pc;
  logic [6:0]  opc;
  logic        is_lsb, is_rs;
  logic        can_issue, illegal;
  logic        full, active, enq, pop, issue, stall;

  assign head_inst = inst_q[head_q];
  assign head_pc   = pc_q[head_q];
  assign opc       = head_inst[6:0];
  assign full      = (count_q == CNT_FULL);

  always_comb begin
    is_lsb = 1'b0;
    is_rs  = 1'b0;
    case (opc)
      7'b0000011, 7'b0100011: is_lsb = 1'b1;
      7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111,
      7'b1100011, 7'b0010011,
      7'b0110011: is_rs = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    can_issue = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      is_lsb:
        can_issue = !bus.rob_full && !bus.lsb_full;
      is_rs:
        can_issue = !bus.rob_full && !bus.rs_full;
      default: illegal = 1'b1;
    endcase
  end

  assign active = rdy && !bus.rollback &&
                  (count_q != '0);
  assign issue  = active && can_issue;
  assign pop    = active && (can_issue || illegal);
  assign stall  = active && !pop;
  // A full queue refuses fetch even if the head pops.
  assign enq    = bus.fetch_valid && !full &&
                  !bus.rollback && rdy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    iv_d    = 1'b0;
    ii_d    = ii_q;
    ipc_d   = ipc_q;
    lsb_d   = lsb_q;
    if (rdy && bus.rollback) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (enq) tail_d = tail_q + PTR_ONE;
      if (pop) head_d = head_q + PTR_ONE;
      if (enq && !pop)
        count_d = count_q + CNT_ONE;
      else if (!enq && pop)
        count_d = count_q - CNT_ONE;
      if (issue) begin
        iv_d  = 1'b1;
        ii_d  = head_inst;
        ipc_d = head_pc;
        lsb_d = is_lsb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      iv_q    <= 1'b0;
      ii_q    <= '0;
      ipc_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      iv_q    <= iv_d;
      ii_q    <= ii_d;
      ipc_q   <= ipc_d;
      lsb_q   <= lsb_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (enq) begin
      inst_q[tail_q] <= bus.fetch_inst;
      pc_q[tail_q]   <= bus.fetch_pc;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] pi_q, pi_d;
  logic [31:0] ps_q, ps_d;

  always_comb begin
    pi_d = pi_q;
    ps_d = ps_q;
    if (issue) pi_d = pi_q + 32'd1;
    if (stall) ps_d = ps_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pi_q <= '0;
      ps_q <= '0;
    end else begin
      pi_q <= pi_d;
      ps_q <= ps_d;
    end
  end

  assign bus.perf_issued = pi_q;
  assign bus.perf_stalls = ps_q;
`else
  logic unused_stall;
  assign unused_stall    = stall;
  assign bus.perf_issued = '0;
  assign bus.perf_stalls = '0;
`endif

  assign bus.iq_full      = full;
  assign bus.issue_valid  = iv_q;
  assign bus.issue_inst   = ii_q;
  assign bus.issue_pc     = ipc_q;
  assign bus.issue_to_lsb = lsb_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: issue, stalls, wrap,
// rollback, illegal pop, rdy freeze and async reset.
module tb_dispatch_scheduler;

`ifdef ISSUE_PERF_CNT_EN
  localparam logic [31:0] PERF_EN = 32'd1;
`else
  localparam logic [31:0] PERF_EN = 32'd0;
`endif

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0000A083;
  localparam logic [31:0] ILL  = 32'h0000007F;

  logic clk;
  logic rst;
  logic rdy;
  int   checks;
  int   failures;

  dispatch_scheduler_if bus ();

  dispatch_scheduler #(
    .IQ_DEPTH(16),
    .IQ_PTR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base,
                      input int n);
    for (int i = 0; i < n; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_inst  = ADDI;
      bus.fetch_pc    = base + 32'(4 * i);
      step();
    end
    bus.fetch_valid = 1'b0;
  endtask

  task automatic drain(input logic [31:0] base,
                       input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk1("drain_iv", bus.issue_valid, 1'b1);
      chk32("drain_pc", bus.issue_pc,
            base + 32'(4 * i));
    end
    step();
    chk1("drain_done_iv", bus.issue_valid, 1'b0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    rdy             = 1'b1;
    bus.fetch_valid = 1'b0;
    bus.fetch_inst  = '0;
    bus.fetch_pc    = '0;
    bus.rob_full    = 1'b0;
    bus.rs_full     = 1'b0;
    bus.lsb_full    = 1'b0;
    bus.rollback    = 1'b0;

    #12;
    chk1("rst_iv", bus.issue_valid, 1'b0);
    chk32("rst_inst", bus.issue_inst, 32'h0);
    chk32("rst_pc", bus.issue_pc, 32'h0);
    chk1("rst_lsb", bus.issue_to_lsb, 1'b0);
    chk1("rst_full", bus.iq_full, 1'b0);
    chk32("rst_pi", bus.perf_issued, 32'h0);
    chk32("rst_ps", bus.perf_stalls, 32'h0);
    rst = 1'b1;
    step();
    chk1("idle_iv", bus.issue_valid, 1'b0);

    // single RS issue, no same-cycle bypass
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = ADDI;
    bus.fetch_pc    = 32'h0;
    step();
    bus.fetch_valid = 1'b0;
    chk1("nobypass_iv", bus.issue_valid, 1'b0);
    step();
    chk1("single_iv", bus.issue_valid, 1'b1);
    chk1("single_lsb", bus.issue_to_lsb, 1'b0);
    chk32("single_pc", bus.issue_pc, 32'h0);
    chk32("single_inst", bus.issue_inst, ADDI);
    step();
    chk1("pulse_iv", bus.issue_valid, 1'b0);

    // LSB stall for three cycles
    bus.lsb_full    = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = LW;
    bus.fetch_pc    = 32'h4;
    step();
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("lsbstall_iv", bus.issue_valid, 1'b0);
    end
    bus.lsb_full = 1'b0;
    step();
    chk1("lsb_iv", bus.issue_valid, 1'b1);
    chk1("lsb_to", bus.issue_to_lsb, 1'b1);
    chk32("lsb_pc", bus.issue_pc, 32'h4);
    chk32("lsb_inst", bus.issue_inst, LW);
    chk32("perf_stalls", bus.perf_stalls,
          32'd3 * PERF_EN);
    chk32("perf_issued", bus.perf_issued,
          32'd2 * PERF_EN);

    // fill to full, 17th held off, drain in order
    bus.rob_full = 1'b1;
    fill(32'h0, 15);
    chk1("almost_full", bus.iq_full, 1'b0);
    fill(32'h3C, 1);
    chk1("full_16", bus.iq_full, 1'b1);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h40;
    step();
    chk1("full_hold", bus.iq_full, 1'b1);
    chk1("full_noiss", bus.issue_valid, 1'b0);
    bus.fetch_valid = 1'b0;
    bus.rob_full    = 1'b0;
    drain(32'h0, 16);
    chk1("drained_full", bus.iq_full, 1'b0);

    // second pass wraps the pointers
    bus.rob_full = 1'b1;
    fill(32'h100, 16);
    chk1("wrap_full", bus.iq_full, 1'b1);
    bus.rob_full = 1'b0;
    drain(32'h100, 16);

    // rollback drops queue and same-cycle fetch
    bus.rob_full = 1'b1;
    fill(32'h200, 5);
    bus.rollback    = 1'b1;
    bus.rob_full    = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = ADDI;
    bus.fetch_pc    = 32'h300;
    step();
    bus.rollback    = 1'b0;
    bus.fetch_valid = 1'b0;
    chk1("rb_iv", bus.issue_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("rb_empty_iv", bus.issue_valid, 1'b0);
    end
    fill(32'h400, 1);
    step();
    chk1("rb_new_iv", bus.issue_valid, 1'b1);
    chk32("rb_new_pc", bus.issue_pc, 32'h400);

    // illegal head popped silently
    bus.fetch_valid = 1'b1;
    bus.fetch_inst  = ILL;
    bus.fetch_pc    = 32'h500;
    step();
    bus.fetch_inst  = ADDI;
    bus.fetch_pc    = 32'h504;
    step();
    bus.fetch_valid = 1'b0;
    chk1("ill_iv", bus.issue_valid, 1'b0);
    step();
    chk1("ill_next_iv", bus.issue_valid, 1'b1);
    chk32("ill_next_pc", bus.issue_pc, 32'h504);

    // rdy low freezes the queue
    fill(32'h600, 1);
    rdy = 1'b0;
    step();
    chk1("rdy0_iv", bus.issue_valid, 1'b0);
    chk32("rdy0_pc", bus.issue_pc, 32'h504);
    step();
    chk1("rdy0_iv2", bus.issue_valid, 1'b0);
    rdy = 1'b1;
    step();
    chk1("rdy1_iv", bus.issue_valid, 1'b1);
    chk32("rdy1_pc", bus.issue_pc, 32'h600);

    // asynchronous reset mid-stream
    bus.rob_full = 1'b1;
    fill(32'h700, 3);
    #2;
    rst = 1'b0;
    #1;
    chk1("arst_iv", bus.issue_valid, 1'b0);
    chk32("arst_pc", bus.issue_pc, 32'h0);
    chk32("arst_inst", bus.issue_inst, 32'h0);
    chk1("arst_full", bus.iq_full, 1'b0);
    chk32("arst_pi", bus.perf_issued, 32'h0);
    #2;
    rst = 1'b1;
    bus.rob_full = 1'b0;
    step();
    chk1("post_rst_iv", bus.issue_valid, 1'b0);
    step();
    chk1("post_rst_iv2", bus.issue_valid, 1'b0);
    chk1("post_rst_full", bus.iq_full, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
